// File: rtl/sm_first_initiator_pkg.sv
// Shared stage-control definitions: chain constants, initiator FSM encoding and defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: CHAIN_WIDTH / MOD_COUNT describe the stage-controller chain;
// DEF_TIMEOUT / DEF_GAP are the initiator defaults; state_t is its FSM encoding.
package sm_first_initiator_pkg;

   localparam int CHAIN_WIDTH = 8;
   localparam int MOD_COUNT   = 4;

   localparam int DEF_TIMEOUT = 64;
   localparam int DEF_GAP     = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FIRE = 2'd1,
      ST_WAIT = 2'd2,
      ST_GAPW = 2'd3
   } state_t;

   // Bits needed to select one stage of the chain.
   function automatic int stage_sel_bits();
      return (MOD_COUNT > 1) ? $clog2(MOD_COUNT) : 1;
   endfunction

endpackage

// File: rtl/sm_first_initiator_sat_counter.sv
// Saturating up-counter with clock enable and synchronous clear.
// Latency: count updates on the enabled edge after inc/clr.
// Backpressure: none; holds at all-ones instead of wrapping.
//
// Ports: clk, rst (sync, active-high), en (clock enable), clr (sync clear, wins
// over inc), inc (count up by one), cnt (current value).
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (en) begin
         if (clr) begin
            cnt <= '0;
         end else if (inc && (cnt != {WIDTH{1'b1}})) begin
            cnt <= cnt + WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/sm_first_initiator.sv
// Packet initiator: fires 'first' into the stage chain, times the return of last_in, enforces an idle gap.
// Latency: all outputs registered; first appears one enabled edge after start, done one enabled edge after last_in.
// Backpressure: one start may be held pending while busy; further starts merge into it.
//
// Ports: clk, rst (sync, active-high), clk_ena (advance enable), start, last_in,
// clr_err -> first (packet-start strobe), busy, done (completion pulse),
// lat (enabled cycles first..last_in), err (bit0 watchdog, bit1 stray last_in).
module sm_first_initiator
   import sm_first_initiator_pkg::*;
#(
   parameter int WIDTH   = CHAIN_WIDTH,
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int GAP     = DEF_GAP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_ena,
   input  logic             start,
   input  logic             last_in,
   input  logic             clr_err,
   output logic             first,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] lat,
   output logic [1:0]       err
);

   // The count seen in a WAIT cycle excludes that cycle, so the watchdog fires
   // on the cycle whose inclusive count equals TIMEOUT.
   localparam logic [WIDTH-1:0] TO_LAST    = WIDTH'(TIMEOUT - 1);
   localparam logic [3:0]       GAP_LAST   = 4'((GAP > 0) ? (GAP - 1) : 0);
   localparam state_t           AFTER_WAIT = (GAP > 0) ? ST_GAPW : ST_IDLE;

   state_t           state;
   state_t           state_n;
   logic             pending;
   logic [3:0]       gap_cnt;
   logic [WIDTH-1:0] cnt;
   logic             wd_hit;

   logic             first_n;
   logic             busy_n;
   logic             done_n;
   logic [WIDTH-1:0] lat_n;
   logic [1:0]       err_n;

   // Shared watchdog / latency count: cleared in FIRE, counts WAIT cycles.
   sat_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk (clk),
      .rst (rst),
      .en  (clk_ena),
      .clr (state == ST_FIRE),
      .inc (state == ST_WAIT),
      .cnt (cnt)
   );

   // last_in on the timeout cycle counts as a normal completion.
   assign wd_hit = (state == ST_WAIT) && !last_in && (cnt == TO_LAST);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else if (clk_ena) begin
         state <= state_n;
      end
   end

   // Next-state logic.
   always_comb begin
      state_n = state;
      unique case (state)
         ST_IDLE: if (start || pending) state_n = ST_FIRE;
         ST_FIRE: state_n = ST_WAIT;
         ST_WAIT: if (last_in || wd_hit) state_n = AFTER_WAIT;
         ST_GAPW: if (gap_cnt == GAP_LAST) state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   // Output next-values; registered below so no input reaches an output combinationally.
   always_comb begin
      first_n = (state_n == ST_FIRE);
      busy_n  = (state_n != ST_IDLE);
      done_n  = (state == ST_WAIT) && last_in;
      lat_n   = done_n ? (cnt + WIDTH'(1)) : lat;
      // A new error is OR-ed in after the clear, so setting wins.
      err_n   = (clr_err ? 2'b00 : err)
              | {last_in && (state != ST_WAIT), wd_hit};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         first <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         lat   <= '0;
         err   <= 2'b00;
      end else if (clk_ena) begin
         first <= first_n;
         busy  <= busy_n;
         done  <= done_n;
         lat   <= lat_n;
         err   <= err_n;
      end
   end

   // Single-entry request latch and inline gap counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= 1'b0;
         gap_cnt <= 4'd0;
      end else if (clk_ena) begin
         if ((state == ST_IDLE) && (state_n == ST_FIRE)) begin
            pending <= 1'b0;
         end else if (start && (state != ST_IDLE)) begin
            pending <= 1'b1;
         end

         if (state != ST_GAPW) begin
            gap_cnt <= 4'd0;
         end else begin
            gap_cnt <= gap_cnt + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_sm_first_initiator.sv
// Bench for sm_first_initiator with default parameters (WIDTH=8, TIMEOUT=64, GAP=2).
// Latency: n/a.
// Backpressure: n/a.
module tb_sm_first_initiator;

   logic       clk = 1'b0;
   logic       rst;
   logic       clk_ena;
   logic       start;
   logic       last_in;
   logic       clr_err;
   logic       first;
   logic       busy;
   logic       done;
   logic [7:0] lat;
   logic [1:0] err;

   always #5 clk = ~clk;

   sm_first_initiator dut (
      .clk     (clk),
      .rst     (rst),
      .clk_ena (clk_ena),
      .start   (start),
      .last_in (last_in),
      .clr_err (clr_err),
      .first   (first),
      .busy    (busy),
      .done    (done),
      .lat     (lat),
      .err     (err)
   );

   int checks = 0;
   int errors = 0;
   int exp_q[$];
   bit tog = 1'b0;
   bit chk_gap = 1'b0;
   int ecyc = 0;
   int first_ecyc = 0;
   int done_ecyc = 0;
   bit have_done = 1'b0;
   bit prev_first = 1'b0;

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   // One enabled cycle; in toggle mode it is followed by one disabled clock.
   task automatic en_step();
      clk_ena = 1'b1;
      @(posedge clk);
      #1;
      if (tog) begin
         clk_ena = 1'b0;
         @(posedge clk);
         #1;
      end
   endtask

   // Called while in FIRE: expect done with lat=n, last_in n enabled cycles after first.
   task automatic finish_packet(input int n);
      exp_q.push_back(n);
      en_step();
      repeat (n - 1) en_step();
      last_in = 1'b1;
      en_step();
      last_in = 1'b0;
   endtask

   task automatic run_packet(input int n);
      start = 1'b1;
      en_step();
      start = 1'b0;
      finish_packet(n);
   endtask

   // Monitor: one observation per enabled cycle, just before the edge that ends it.
   always @(negedge clk) begin
      if (rst) begin
         prev_first = 1'b0;
         have_done  = 1'b0;
      end else if (clk_ena) begin
         ecyc++;
         if (first) begin
            checks++;
            if (prev_first) begin
               errors++;
               $display("FAIL first_width: got first high for 2+ enabled cycles expected 1");
            end else begin
               if (chk_gap && have_done && (done_ecyc > first_ecyc)) begin
                  checks++;
                  if (ecyc - done_ecyc != 3) begin
                     errors++;
                     $display("FAIL done_to_first: got %0d expected 3", ecyc - done_ecyc);
                  end
               end
               first_ecyc = ecyc;
            end
         end
         prev_first = first;
         if (done) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done: got done=1 expected none (lat=%0d)", lat);
            end else begin
               int e;
               e = exp_q.pop_front();
               if (lat != e[7:0]) begin
                  errors++;
                  $display("FAIL sb_lat: got %0d expected %0d", lat, e);
               end
               checks++;
               if (ecyc - first_ecyc != e + 1) begin
                  errors++;
                  $display("FAIL sb_first_to_done: got %0d expected %0d", ecyc - first_ecyc, e + 1);
               end
            end
            done_ecyc = ecyc;
            have_done = 1'b1;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1, "simulation time limit");
   end

   initial begin
      rst     = 1'b1;
      clk_ena = 1'b0;
      start   = 1'b0;
      last_in = 1'b0;
      clr_err = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_first", first, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_lat", lat, 0);
      chk("rst_err", err, 0);
      rst = 1'b0;
      en_step();

      // Basic packet, lat 60.
      start = 1'b1;
      en_step();
      start = 1'b0;
      chk("t1_first", first, 1);
      chk("t1_busy", busy, 1);
      exp_q.push_back(60);
      en_step();
      chk("t1_first_low", first, 0);
      repeat (59) en_step();
      last_in = 1'b1;
      en_step();
      last_in = 1'b0;
      chk("t1_done", done, 1);
      chk("t1_lat", lat, 60);
      chk("t1_err", err, 0);
      chk("t1_busy_gap", busy, 1);
      en_step();
      chk("t1_done_pulse", done, 0);
      chk("t1_busy_gap2", busy, 1);
      en_step();
      chk("t1_busy_low", busy, 0);

      // Toggling clk_ena: first held over the disabled clock, lat counts enabled cycles.
      tog = 1'b1;
      exp_q.push_back(60);
      clk_ena = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      chk("t2_first", first, 1);
      clk_ena = 1'b0;
      start = 1'b0;
      @(posedge clk);
      #1;
      chk("t2_first_held", first, 1);
      en_step();
      chk("t2_first_low", first, 0);
      repeat (59) en_step();
      last_in = 1'b1;
      en_step();
      last_in = 1'b0;
      chk("t2_done", done, 1);
      chk("t2_lat", lat, 60);
      tog = 1'b0;
      repeat (3) en_step();

      // Watchdog timeout: err[0] after 64 WAIT cycles, lat untouched.
      start = 1'b1;
      en_step();
      start = 1'b0;
      en_step();
      repeat (63) en_step();
      chk("t3_err_before", err, 0);
      en_step();
      chk("t3_err_timeout", err, 1);
      chk("t3_no_done", done, 0);
      chk("t3_lat_kept", lat, 60);
      clr_err = 1'b1;
      en_step();
      clr_err = 1'b0;
      chk("t3_err_cleared", err, 0);
      en_step();
      chk("t3_idle", busy, 0);

      // start held high: firsts exactly 3 enabled cycles after each done.
      chk_gap = 1'b1;
      start = 1'b1;
      en_step();
      for (int p = 0; p < 3; p++) begin
         chk("t4_first", first, 1);
         finish_packet(5);
         chk("t4_lat", lat, 5);
         en_step();
         en_step();
         chk("t4_idle_first", first, 0);
         chk("t4_idle_busy", busy, 0);
         en_step();
      end
      start = 1'b0;
      chk("t4_first_last", first, 1);
      finish_packet(5);
      chk_gap = 1'b0;
      repeat (3) en_step();
      chk("t4_drained", busy, 0);

      // Stray last_in in IDLE, set beats clear, then last_in on the timeout cycle.
      last_in = 1'b1;
      en_step();
      last_in = 1'b0;
      chk("t5_stray_err", err, 2);
      chk("t5_stray_busy", busy, 0);
      chk("t5_stray_first", first, 0);
      last_in = 1'b1;
      clr_err = 1'b1;
      en_step();
      last_in = 1'b0;
      chk("t5_set_wins", err, 2);
      en_step();
      clr_err = 1'b0;
      chk("t5_cleared", err, 0);
      run_packet(64);
      chk("t5_to_done", done, 1);
      chk("t5_to_lat", lat, 64);
      chk("t5_to_err", err, 0);
      repeat (3) en_step();

      // Reset during WAIT with clk_ena low, then a late last_in is stray.
      start = 1'b1;
      en_step();
      start = 1'b0;
      repeat (6) en_step();
      chk("t6_busy_before", busy, 1);
      clk_ena = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("t6_first", first, 0);
      chk("t6_busy", busy, 0);
      chk("t6_done", done, 0);
      chk("t6_lat", lat, 0);
      chk("t6_err", err, 0);
      en_step();
      chk("t6_stays_idle", busy, 0);
      last_in = 1'b1;
      en_step();
      last_in = 1'b0;
      chk("t6_stray_err", err, 2);
      chk("t6_no_done", done, 0);
      repeat (2) en_step();

      chk("exp_q_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
